// File: rtl/rf_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// rf_ctx_ctrl
//
// Subroutine context controller. Sequences CALL and RET instructions by
// saving/restoring register-file frames and the return address, and by
// redirecting the program counter. Overflow of the frame stack and
// underflow on return are reported through sticky error flags.
//
// Parameters
//   PC_WIDTH  width of program-counter values and of the frame stack pointer
//   DEPTH     maximum number of saved frames (1 .. 2**PC_WIDTH-1)
//
// Ports
//   clk               single clock, rising edge
//   rst_n             asynchronous active-low reset
//   call_req          level request to enter a subroutine, held until req_ack
//   ret_req           level request to return, held until req_ack
//   pc_cur            address of the CALL instruction, sampled at acceptance
//   call_target       jump address, sampled at acceptance
//   err_clr           clears ovf_err / unf_err on the next edge
//   req_ack           one-cycle pulse ending every accepted request
//   busy              high whenever the sequencer is not idle
//   rf_stack_push     register file: snapshot frame at rf_stack_pointer
//   rf_stack_pop      register file: restore frame at rf_stack_pointer
//   rf_stack_pointer  number of saved frames (0 = none)
//   pc_load           one-cycle strobe: PC takes pc_load_val
//   pc_load_val       new PC value, meaningful only with pc_load
//   ovf_err           sticky: call attempted with a full frame stack
//   unf_err           sticky: return attempted with an empty frame stack
// ---------------------------------------------------------------------------
module rf_ctx_ctrl #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic [PC_WIDTH-1:0] pc_cur,
  input  logic [PC_WIDTH-1:0] call_target,
  input  logic                err_clr,
  output logic                req_ack,
  output logic                busy,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_load_val,
  output logic                ovf_err,
  output logic                unf_err
);

  // Return-address storage is indexed by frame number 1..DEPTH; entry 0 is
  // never used, which keeps the index equal to the stack pointer value.
  localparam int                IDX_W  = $clog2(DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] SP_MAX = PC_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    C_INC,
    C_PUSH,
    C_JUMP,
    R_POP,
    R_JUMP,
    ERR
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] sp;
  logic [PC_WIDTH-1:0] sp_inc;
  logic [PC_WIDTH-1:0] sp_dec;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] retaddr;
  logic [PC_WIDTH-1:0] ret_mem [0:DEPTH];

  logic sp_full;
  logic sp_empty;
  logic accept_call;
  logic accept_ret;
  logic ovf_set;
  logic unf_set;

  assign sp_inc   = sp + PC_WIDTH'(1);
  assign sp_dec   = sp - PC_WIDTH'(1);
  assign sp_full  = (sp == SP_MAX);
  assign sp_empty = (sp == '0);

  // Requests are only looked at in IDLE; call wins a tie and a simultaneous
  // ret_req simply stays pending until the call has completed.
  assign accept_call = (state == IDLE) && call_req;
  assign accept_ret  = (state == IDLE) && !call_req && ret_req;
  assign ovf_set     = accept_call && sp_full;
  assign unf_set     = accept_ret && sp_empty;

  assign rf_stack_pointer = sp;

  // Call operands are captured at acceptance so the requester may change
  // pc_cur / call_target while the sequence runs. Return address wraps
  // modulo 2**PC_WIDTH.
  always_ff @(posedge clk) begin
    if (accept_call) begin
      target  <= call_target;
      retaddr <= pc_cur + PC_WIDTH'(1);
    end
  end

  // Return addresses are plain storage: not reset, and a slot is only read
  // after a completed C_INC has written it.
  always_ff @(posedge clk) begin
    if (state == C_INC) begin
      ret_mem[sp_inc[IDX_W-1:0]] <= retaddr;
    end
  end

  // Sequencer. Every output is a register written on the transition into
  // the state in which it must be visible, so strobes line up exactly with
  // the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sp            <= '0;
      req_ack       <= 1'b0;
      busy          <= 1'b0;
      rf_stack_push <= 1'b0;
      rf_stack_pop  <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_val   <= '0;
      ovf_err       <= 1'b0;
      unf_err       <= 1'b0;
    end else begin
      req_ack       <= 1'b0;
      rf_stack_push <= 1'b0;
      rf_stack_pop  <= 1'b0;
      pc_load       <= 1'b0;

      // Set has priority over clear.
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);

      case (state)
        IDLE: begin
          if (accept_call) begin
            busy <= 1'b1;
            if (sp_full) begin
              state   <= ERR;
              req_ack <= 1'b1;
            end else begin
              state <= C_INC;
            end
          end else if (accept_ret) begin
            busy <= 1'b1;
            if (sp_empty) begin
              state   <= ERR;
              req_ack <= 1'b1;
            end else begin
              state        <= R_POP;
              rf_stack_pop <= 1'b1;
            end
          end
        end

        // SP advances here so the push strobe already sees the new frame.
        C_INC: begin
          sp            <= sp_inc;
          state         <= C_PUSH;
          rf_stack_push <= 1'b1;
        end

        C_PUSH: begin
          state       <= C_JUMP;
          pc_load     <= 1'b1;
          pc_load_val <= target;
          req_ack     <= 1'b1;
        end

        C_JUMP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        R_POP: begin
          state       <= R_JUMP;
          pc_load     <= 1'b1;
          pc_load_val <= ret_mem[sp[IDX_W-1:0]];
          req_ack     <= 1'b1;
        end

        // SP drops only after the pop and the jump have both used it.
        R_JUMP: begin
          sp    <= sp_dec;
          state <= IDLE;
          busy  <= 1'b0;
        end

        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_ctx_ctrl
//
// Self-checking bench for rf_ctx_ctrl: a table of per-cycle vectors for the
// basic call / return / underflow / error-clear behaviour, followed by
// hand-written sequences for nesting, overflow, priority and reset abort.
// ---------------------------------------------------------------------------
module tb_rf_ctx_ctrl;

  localparam int PW    = 5;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          call_req;
  logic          ret_req;
  logic [PW-1:0] pc_cur;
  logic [PW-1:0] call_target;
  logic          err_clr;
  logic          req_ack;
  logic          busy;
  logic          rf_stack_push;
  logic          rf_stack_pop;
  logic [PW-1:0] rf_stack_pointer;
  logic          pc_load;
  logic [PW-1:0] pc_load_val;
  logic          ovf_err;
  logic          unf_err;

  int checks   = 0;
  int failures = 0;

  // Reference state: SP, last loaded PC, sticky flags, return-address LIFO.
  int            m_sp;
  logic [PW-1:0] m_pcv;
  logic          m_ovf;
  logic          m_unf;
  logic [PW-1:0] m_stack [$];

  rf_ctx_ctrl #(.PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .call_req         (call_req),
    .ret_req          (ret_req),
    .pc_cur           (pc_cur),
    .call_target      (call_target),
    .err_clr          (err_clr),
    .req_ack          (req_ack),
    .busy             (busy),
    .rf_stack_push    (rf_stack_push),
    .rf_stack_pop     (rf_stack_pop),
    .rf_stack_pointer (rf_stack_pointer),
    .pc_load          (pc_load),
    .pc_load_val      (pc_load_val),
    .ovf_err          (ovf_err),
    .unf_err          (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          call;
    logic          ret;
    logic          clr;
    logic [PW-1:0] pc;
    logic [PW-1:0] tgt;
    logic          ack;
    logic          bsy;
    logic          psh;
    logic          pop;
    logic          pcl;
    logic [PW-1:0] pcv;
    logic [PW-1:0] sp;
    logic          ovf;
    logic          unf;
  } vec_t;

  function automatic vec_t mk(input int c, input int r, input int cl,
                              input int pc, input int tg,
                              input int ack, input int bsy, input int psh,
                              input int pop, input int pcl,
                              input int pcv, input int sp,
                              input int ovf, input int unf);
    vec_t v;
    v.call = 1'(c);   v.ret = 1'(r);    v.clr = 1'(cl);
    v.pc   = PW'(pc); v.tgt = PW'(tg);
    v.ack  = 1'(ack); v.bsy = 1'(bsy);  v.psh = 1'(psh);
    v.pop  = 1'(pop); v.pcl = 1'(pcl);
    v.pcv  = PW'(pcv); v.sp = PW'(sp);
    v.ovf  = 1'(ovf); v.unf = 1'(unf);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs; strobes given explicitly, the rest from the model.
  task automatic exp_out(input string tag, input logic ack, input logic bsy,
                         input logic psh, input logic pop, input logic pcl);
    check({tag, ".req_ack"}, 32'(req_ack), 32'(ack));
    check({tag, ".busy"},    32'(busy), 32'(bsy));
    check({tag, ".push"},    32'(rf_stack_push), 32'(psh));
    check({tag, ".pop"},     32'(rf_stack_pop), 32'(pop));
    check({tag, ".pc_load"}, 32'(pc_load), 32'(pcl));
    check({tag, ".pc_val"},  32'(pc_load_val), 32'(m_pcv));
    check({tag, ".sp"},      32'(rf_stack_pointer), 32'(m_sp));
    check({tag, ".ovf"},     32'(ovf_err), 32'(m_ovf));
    check({tag, ".unf"},     32'(unf_err), 32'(m_unf));
  endtask

  task automatic do_call(input string tag, input logic [PW-1:0] pc,
                         input logic [PW-1:0] tgt);
    call_req    = 1'b1;
    pc_cur      = pc;
    call_target = tgt;
    step();
    if (m_sp < DEPTH) begin
      exp_out({tag, ".inc"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      m_sp++;
      exp_out({tag, ".push"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      m_pcv = tgt;
      m_stack.push_back(pc + PW'(1));
      exp_out({tag, ".jump"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      m_ovf = 1'b1;
      exp_out({tag, ".ovf"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    call_req = 1'b0;
    step();
    exp_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ret(input string tag);
    ret_req = 1'b1;
    step();
    if (m_sp > 0) begin
      exp_out({tag, ".pop"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      m_pcv = m_stack.pop_back();
      exp_out({tag, ".jump"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      ret_req = 1'b0;
      step();
      m_sp--;
    end else begin
      m_unf = 1'b1;
      exp_out({tag, ".unf"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ret_req = 1'b0;
      step();
    end
    exp_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vt [15];

  initial begin
    // Basic call(5->20), return(->6), underflow, clear, set-beats-clear.
    vt[0]  = mk(1,0,0, 5,20,  0,1,0,0,0,  0,0, 0,0);
    vt[1]  = mk(1,0,0, 5,20,  0,1,1,0,0,  0,1, 0,0);
    vt[2]  = mk(1,0,0, 5,20,  1,1,0,0,1, 20,1, 0,0);
    vt[3]  = mk(0,0,0, 0, 0,  0,0,0,0,0, 20,1, 0,0);
    vt[4]  = mk(0,1,0, 0, 0,  0,1,0,1,0, 20,1, 0,0);
    vt[5]  = mk(0,1,0, 0, 0,  1,1,0,0,1,  6,1, 0,0);
    vt[6]  = mk(0,0,0, 0, 0,  0,0,0,0,0,  6,0, 0,0);
    vt[7]  = mk(0,1,0, 0, 0,  1,1,0,0,0,  6,0, 0,1);
    vt[8]  = mk(0,0,0, 0, 0,  0,0,0,0,0,  6,0, 0,1);
    vt[9]  = mk(0,0,1, 0, 0,  0,0,0,0,0,  6,0, 0,0);
    vt[10] = mk(0,1,0, 0, 0,  1,1,0,0,0,  6,0, 0,1);
    vt[11] = mk(0,0,0, 0, 0,  0,0,0,0,0,  6,0, 0,1);
    vt[12] = mk(0,1,1, 0, 0,  1,1,0,0,0,  6,0, 0,1);
    vt[13] = mk(0,0,0, 0, 0,  0,0,0,0,0,  6,0, 0,1);
    vt[14] = mk(0,0,1, 0, 0,  0,0,0,0,0,  6,0, 0,0);

    rst_n       = 1'b0;
    call_req    = 1'b0;
    ret_req     = 1'b0;
    pc_cur      = '0;
    call_target = '0;
    err_clr     = 1'b0;
    m_sp  = 0;
    m_pcv = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    step();
    step();
    exp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    exp_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      call_req    = vt[i].call;
      ret_req     = vt[i].ret;
      err_clr     = vt[i].clr;
      pc_cur      = vt[i].pc;
      call_target = vt[i].tgt;
      step();
      check($sformatf("vec%0d.req_ack", i), 32'(req_ack), 32'(vt[i].ack));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].bsy));
      check($sformatf("vec%0d.push", i), 32'(rf_stack_push), 32'(vt[i].psh));
      check($sformatf("vec%0d.pop", i), 32'(rf_stack_pop), 32'(vt[i].pop));
      check($sformatf("vec%0d.pc_load", i), 32'(pc_load), 32'(vt[i].pcl));
      check($sformatf("vec%0d.pc_val", i), 32'(pc_load_val), 32'(vt[i].pcv));
      check($sformatf("vec%0d.sp", i), 32'(rf_stack_pointer), 32'(vt[i].sp));
      check($sformatf("vec%0d.ovf", i), 32'(ovf_err), 32'(vt[i].ovf));
      check($sformatf("vec%0d.unf", i), 32'(unf_err), 32'(vt[i].unf));
    end
    call_req = 1'b0;
    ret_req  = 1'b0;
    err_clr  = 1'b0;
    m_sp  = 0;
    m_pcv = PW'(6);
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // Fill the frame stack, overflow once, then unwind in LIFO order.
    for (int i = 0; i < DEPTH; i++)
      do_call($sformatf("nest%0d", i), PW'(i * 3 + 2), PW'(31 - i));
    do_call("ninth", PW'(30), PW'(1));
    for (int i = 0; i < DEPTH; i++)
      do_ret($sformatf("unwind%0d", i));
    err_clr = 1'b1;
    step();
    m_ovf = 1'b0;
    exp_out("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;

    // Simultaneous call and ret at SP = 2: call first, ret stays pending.
    do_call("pre0", PW'(10), PW'(3));
    do_call("pre1", PW'(12), PW'(7));
    call_req    = 1'b1;
    ret_req     = 1'b1;
    pc_cur      = PW'(31);
    call_target = PW'(9);
    step();
    exp_out("both.inc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    m_sp = 3;
    exp_out("both.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    m_pcv = PW'(9);
    exp_out("both.cjump", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    call_req = 1'b0;
    step();
    exp_out("both.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_out("both.pop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    m_pcv = PW'(0);
    exp_out("both.rjump", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    ret_req = 1'b0;
    step();
    m_sp = 2;
    exp_out("both.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_stack.delete();
    m_stack.push_back(PW'(11));
    m_stack.push_back(PW'(13));
    do_ret("post0");
    do_ret("post1");

    // Reset asserted while the push strobe is high.
    call_req    = 1'b1;
    pc_cur      = PW'(1);
    call_target = PW'(2);
    step();
    exp_out("abort.inc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    m_sp = 1;
    exp_out("abort.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_sp  = 0;
    m_pcv = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stack.delete();
    exp_out("abort.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    call_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_out($sformatf("abort.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
